// File: rtl/cave_input_ctrl_pkg.sv
// Shared definitions for the CAVE input controller: PS/2 set-2 scan codes,
// MiSTer joystick bit positions and the per-player control bundle.
package cave_input_pkg;

    localparam logic [7:0] SC_P1_UP    = 8'h75;
    localparam logic [7:0] SC_P1_DOWN  = 8'h72;
    localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT = 8'h74;
    localparam logic [7:0] SC_P1_B1    = 8'h14;
    localparam logic [7:0] SC_P1_B2    = 8'h11;
    localparam logic [7:0] SC_P1_B3    = 8'h29;
    localparam logic [7:0] SC_P1_START = 8'h16;
    localparam logic [7:0] SC_P1_COIN  = 8'h2E;
    localparam logic [7:0] SC_P1_PAUSE = 8'h4D;

    localparam logic [7:0] SC_P2_UP    = 8'h2D;
    localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
    localparam logic [7:0] SC_P2_LEFT  = 8'h23;
    localparam logic [7:0] SC_P2_RIGHT = 8'h34;
    localparam logic [7:0] SC_P2_B1    = 8'h1C;
    localparam logic [7:0] SC_P2_B2    = 8'h1B;
    localparam logic [7:0] SC_P2_B3    = 8'h15;
    localparam logic [7:0] SC_P2_START = 8'h1E;
    localparam logic [7:0] SC_P2_COIN  = 8'h36;

    localparam logic [7:0] SC_SERVICE1 = 8'h46;
    localparam logic [7:0] SC_SERVICE2 = 8'h45;

    localparam int JB_RIGHT   = 0;
    localparam int JB_LEFT    = 1;
    localparam int JB_DOWN    = 2;
    localparam int JB_UP      = 3;
    localparam int JB_B1      = 4;
    localparam int JB_B2      = 5;
    localparam int JB_B3      = 6;
    localparam int JB_START   = 7;
    localparam int JB_COIN    = 8;
    localparam int JB_PAUSE   = 9;
    localparam int JB_SERVICE = 10;

    typedef struct packed {
        logic       up;
        logic       down;
        logic       left;
        logic       right;
        logic [2:0] buttons;
        logic       start;
        logic       coin;
        logic       pause;
    } player_ctrl_t;

    function automatic player_ctrl_t joy_to_ctrl(input logic [10:0] j);
        player_ctrl_t c;
        c.up      = j[JB_UP];
        c.down    = j[JB_DOWN];
        c.left    = j[JB_LEFT];
        c.right   = j[JB_RIGHT];
        c.buttons = {j[JB_B3], j[JB_B2], j[JB_B1]};
        c.start   = j[JB_START];
        c.coin    = j[JB_COIN];
        c.pause   = j[JB_PAUSE];
        return c;
    endfunction

endpackage

// File: rtl/cave_input_ctrl_if.sv
// Bundle of HPS input words and per-player control outputs between hps_io and Main.
interface cave_input_ctrl_if;
    logic [10:0] ps2_key;
    logic [31:0] joystick_0;
    logic [31:0] joystick_1;

    logic       p1_up, p1_down, p1_left, p1_right, p1_start, p1_coin, p1_pause;
    logic [2:0] p1_buttons;
    logic       p2_up, p2_down, p2_left, p2_right, p2_start, p2_coin, p2_pause;
    logic [2:0] p2_buttons;
    logic       service1, service2;

    modport master (
        output ps2_key, joystick_0, joystick_1,
        input  p1_up, p1_down, p1_left, p1_right, p1_start, p1_coin, p1_pause, p1_buttons,
        input  p2_up, p2_down, p2_left, p2_right, p2_start, p2_coin, p2_pause, p2_buttons,
        input  service1, service2
    );

    modport slave (
        input  ps2_key, joystick_0, joystick_1,
        output p1_up, p1_down, p1_left, p1_right, p1_start, p1_coin, p1_pause, p1_buttons,
        output p2_up, p2_down, p2_left, p2_right, p2_start, p2_coin, p2_pause, p2_buttons,
        output service1, service2
    );
endinterface

// File: rtl/cave_input_ctrl_coin_stretcher.sv
// Coin pulse stretcher: holds the output high for at least COIN_PULSE+1 cycles
// after each rising edge of the raw coin input, retriggering on every new edge.
module coin_stretcher #(
    parameter int unsigned COIN_PULSE = 4_800_000
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic out
);
    localparam int CW = $clog2(COIN_PULSE + 1);

    logic [CW-1:0] count;
    logic          in_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count   <= '0;
            in_prev <= 1'b0;
        end else begin
            in_prev <= in;
            if (in && !in_prev)
                count <= CW'(COIN_PULSE);
            else if (count != '0)
                count <= count - CW'(1);
        end
    end

    assign out = in | (count != '0);
endmodule

// File: rtl/cave_input_ctrl.sv
// Keyboard/joystick to per-player control mapping for the CAVE core: PS/2
// make/break tracking, pause toggle latches, coin stretch and output pipeline.
module cave_input_ctrl
    import cave_input_pkg::*;
#(
    parameter logic [23:0] COIN_PULSE = 24'd4_800_000
) (
    input  logic              clock,
    input  logic              reset,
    cave_input_ctrl_if.slave  bus
);
    logic [10:0]  key_s0;
    logic [10:0]  joy0_s0, joy1_s0;
    logic         toggle_prev, primed;
    player_ctrl_t key_p1, key_p2;
    logic         key_svc1, key_svc2;
    player_ctrl_t raw_p1, raw_p2;
    logic         pause_prev1, pause_prev2, pause_lat1, pause_lat2;
    logic         coin_out1, coin_out2;
    player_ctrl_t out_p1, out_p2;
    logic         out_svc1, out_svc2;
    logic         key_event;

    logic unused_bits;
    assign unused_bits = ^{key_s0[8], bus.joystick_0[31:11], bus.joystick_1[31:11]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_s0  <= '0;
            joy0_s0 <= '0;
            joy1_s0 <= '0;
        end else begin
            key_s0  <= bus.ps2_key;
            joy0_s0 <= bus.joystick_0[10:0];
            joy1_s0 <= bus.joystick_1[10:0];
        end
    end

    assign key_event = primed && (key_s0[10] != toggle_prev);

    // Until primed, track the live toggle so a 1 held across reset release is not an event.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            primed      <= 1'b0;
            toggle_prev <= 1'b0;
            key_p1      <= '0;
            key_p2      <= '0;
            key_svc1    <= 1'b0;
            key_svc2    <= 1'b0;
        end else begin
            primed      <= 1'b1;
            toggle_prev <= primed ? key_s0[10] : bus.ps2_key[10];
            if (key_event) begin
                case (key_s0[7:0])
                    SC_P1_UP:    key_p1.up         <= key_s0[9];
                    SC_P1_DOWN:  key_p1.down       <= key_s0[9];
                    SC_P1_LEFT:  key_p1.left       <= key_s0[9];
                    SC_P1_RIGHT: key_p1.right      <= key_s0[9];
                    SC_P1_B1:    key_p1.buttons[0] <= key_s0[9];
                    SC_P1_B2:    key_p1.buttons[1] <= key_s0[9];
                    SC_P1_B3:    key_p1.buttons[2] <= key_s0[9];
                    SC_P1_START: key_p1.start      <= key_s0[9];
                    SC_P1_COIN:  key_p1.coin       <= key_s0[9];
                    SC_P1_PAUSE: key_p1.pause      <= key_s0[9];
                    SC_P2_UP:    key_p2.up         <= key_s0[9];
                    SC_P2_DOWN:  key_p2.down       <= key_s0[9];
                    SC_P2_LEFT:  key_p2.left       <= key_s0[9];
                    SC_P2_RIGHT: key_p2.right      <= key_s0[9];
                    SC_P2_B1:    key_p2.buttons[0] <= key_s0[9];
                    SC_P2_B2:    key_p2.buttons[1] <= key_s0[9];
                    SC_P2_B3:    key_p2.buttons[2] <= key_s0[9];
                    SC_P2_START: key_p2.start      <= key_s0[9];
                    SC_P2_COIN:  key_p2.coin       <= key_s0[9];
                    SC_SERVICE1: key_svc1          <= key_s0[9];
                    SC_SERVICE2: key_svc2          <= key_s0[9];
                    default: ;
                endcase
            end
        end
    end

    assign raw_p1 = player_ctrl_t'(key_p1 | joy_to_ctrl(joy0_s0));
    assign raw_p2 = player_ctrl_t'(key_p2 | joy_to_ctrl(joy1_s0));

    // Edge is taken on the combined key|joystick level so simultaneous sources toggle once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pause_prev1 <= 1'b0;
            pause_prev2 <= 1'b0;
            pause_lat1  <= 1'b0;
            pause_lat2  <= 1'b0;
        end else begin
            pause_prev1 <= raw_p1.pause;
            pause_prev2 <= raw_p2.pause;
            if (raw_p1.pause && !pause_prev1) pause_lat1 <= ~pause_lat1;
            if (raw_p2.pause && !pause_prev2) pause_lat2 <= ~pause_lat2;
        end
    end

    coin_stretcher #(.COIN_PULSE(32'(COIN_PULSE))) u_coin1 (
        .clock(clock), .reset(reset), .in(raw_p1.coin), .out(coin_out1)
    );
    coin_stretcher #(.COIN_PULSE(32'(COIN_PULSE))) u_coin2 (
        .clock(clock), .reset(reset), .in(raw_p2.coin), .out(coin_out2)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_p1   <= '0;
            out_p2   <= '0;
            out_svc1 <= 1'b0;
            out_svc2 <= 1'b0;
        end else begin
            out_p1       <= raw_p1;
            out_p1.coin  <= coin_out1;
            out_p1.pause <= pause_lat1;
            out_p2       <= raw_p2;
            out_p2.coin  <= coin_out2;
            out_p2.pause <= pause_lat2;
            out_svc1     <= key_svc1 | joy0_s0[JB_SERVICE];
            out_svc2     <= key_svc2 | joy1_s0[JB_SERVICE];
        end
    end

    assign bus.p1_up      = out_p1.up;
    assign bus.p1_down    = out_p1.down;
    assign bus.p1_left    = out_p1.left;
    assign bus.p1_right   = out_p1.right;
    assign bus.p1_buttons = out_p1.buttons;
    assign bus.p1_start   = out_p1.start;
    assign bus.p1_coin    = out_p1.coin;
    assign bus.p1_pause   = out_p1.pause;
    assign bus.p2_up      = out_p2.up;
    assign bus.p2_down    = out_p2.down;
    assign bus.p2_left    = out_p2.left;
    assign bus.p2_right   = out_p2.right;
    assign bus.p2_buttons = out_p2.buttons;
    assign bus.p2_start   = out_p2.start;
    assign bus.p2_coin    = out_p2.coin;
    assign bus.p2_pause   = out_p2.pause;
    assign bus.service1   = out_svc1;
    assign bus.service2   = out_svc2;
endmodule

// File: tb/tb_cave_input_ctrl.sv
// Bench for cave_input_ctrl: history-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_cave_input_ctrl;
    localparam int CP   = 10;
    localparam int MAXC = 4095;
    localparam int NK   = 21;

    logic clk = 1'b0;
    logic rst = 1'b1;
    cave_input_ctrl_if bus();

    cave_input_ctrl #(.COIN_PULSE(24'(CP))) dut (.clock(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Raw vector layout: per player [0]up [1]down [2]left [3]right [4..6]B1..B3
    // [7]start [8]coin [9]pause; p1 at 0..9, p2 at 10..19, service1 20, service2 21.
    logic [7:0] key_code [NK] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h16, 8'h2E, 8'h4D,
                                  8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h15, 8'h1E, 8'h36,
                                  8'h46, 8'h45};
    int         key_bit  [NK] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9,
                                  10, 11, 12, 13, 14, 15, 16, 17, 18,
                                  20, 21};

    logic [10:0] h_ps2 [0:MAXC];
    logic [21:0] raw_h [0:MAXC];
    logic [21:0] mdown;
    int          t = 0;

    function automatic logic [9:0] joymap(input logic [31:0] j);
        return {j[9], j[8], j[7], j[6], j[5], j[4], j[0], j[1], j[2], j[3]};
    endfunction

    // t counts clock edges since reset release; h_ps2[t] is what edge t sampled.
    always @(posedge clk) begin
        if (rst) begin
            t        = 0;
            mdown    = '0;
            raw_h[0] = '0;
        end else if (t < MAXC) begin
            t++;
            h_ps2[t] = bus.ps2_key;
            if (t >= 3 && h_ps2[t-1][10] != h_ps2[t-2][10]) begin
                for (int k = 0; k < NK; k++)
                    if (key_code[k] == h_ps2[t-1][7:0]) mdown[key_bit[k]] = h_ps2[t-1][9];
            end
            raw_h[t] = mdown | {bus.joystick_1[10], bus.joystick_0[10],
                                joymap(bus.joystick_1), joymap(bus.joystick_0)};
        end
    end

    function automatic logic [21:0] expect_at(input int n);
        logic [21:0] e;
        int pc1, pc2, lo;
        if (n < 2) return '0;
        e = raw_h[n-1];
        pc1 = 0;
        pc2 = 0;
        for (int k = 1; k <= n - 2; k++) begin
            if (raw_h[k][9]  && !raw_h[k-1][9])  pc1++;
            if (raw_h[k][19] && !raw_h[k-1][19]) pc2++;
        end
        e[9]  = pc1[0];
        e[19] = pc2[0];
        lo = (n - 1 - CP < 1) ? 1 : n - 1 - CP;
        for (int k = lo; k <= n - 2; k++) begin
            if (raw_h[k][8]  && !raw_h[k-1][8])  e[8]  = 1'b1;
            if (raw_h[k][18] && !raw_h[k-1][18]) e[18] = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [21:0] dut_vec();
        return {bus.service2, bus.service1,
                bus.p2_pause, bus.p2_coin, bus.p2_start, bus.p2_buttons,
                bus.p2_right, bus.p2_left, bus.p2_down, bus.p2_up,
                bus.p1_pause, bus.p1_coin, bus.p1_start, bus.p1_buttons,
                bus.p1_right, bus.p1_left, bus.p1_down, bus.p1_up};
    endfunction

    always @(negedge clk) begin
        logic [21:0] exp_v, got_v;
        exp_v = rst ? 22'h0 : expect_at(t);
        got_v = dut_vec();
        checks++;
        if (got_v === exp_v) passed++;
        else $display("FAIL model_cycle t=%0d outputs got %h expected %h", t, got_v, exp_v);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got %0h expected %0h", name, got, exp);
    endtask

    task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
        @(negedge clk);
        bus.ps2_key = {~bus.ps2_key[10], pressed, ext, code};
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int cnt, first, last;
        logic [31:0] jpat [5] = '{32'h0000_000F, 32'h0000_0070, 32'h0000_0480, 32'hFFFF_F800, 32'h0000_0000};

        bus.ps2_key    = 11'h400;
        bus.joystick_0 = '0;
        bus.joystick_1 = '0;
        cycles(3);
        rst = 1'b0;

        // Toggle bit high across reset release must not produce an event.
        cycles(100);
        check("prime_all_zero", 32'(dut_vec()), 0);

        send_key(1'b1, 1'b0, 8'h75);
        cycles(2);
        check("p1_up_make_t2", 32'(bus.p1_up), 0);
        cycles(1);
        check("p1_up_make_t3", 32'(bus.p1_up), 1);
        check("p2_idle_on_p1_key", 32'(dut_vec() >> 10), 0);
        cycles(5);
        send_key(1'b0, 1'b0, 8'h75);
        cycles(2);
        check("p1_up_break_t2", 32'(bus.p1_up), 1);
        cycles(1);
        check("p1_up_break_t3", 32'(bus.p1_up), 0);

        // Every mapped key except pause, an unlisted code, and an extended make.
        for (int k = 0; k < NK; k++) begin
            if (k != 9) begin
                send_key(1'b1, 1'b0, key_code[k]);
                cycles(4);
                send_key(1'b0, 1'b0, key_code[k]);
                cycles(3);
            end
        end
        send_key(1'b1, 1'b0, 8'h5A);
        cycles(4);
        send_key(1'b1, 1'b1, 8'h72);
        cycles(4);
        check("ext_bit_ignored_down", 32'(bus.p1_down), 1);
        send_key(1'b0, 1'b0, 8'h72);
        cycles(4);

        foreach (jpat[i]) begin
            @(negedge clk);
            bus.joystick_0 = jpat[i];
            bus.joystick_1 = ~jpat[i] & 32'h0000_04FF;
            cycles(3);
        end
        bus.joystick_0 = '0;
        bus.joystick_1 = '0;
        cycles(15);

        // Single-cycle joystick coin on player 2.
        @(negedge clk);
        bus.joystick_1 = 32'h100;
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) bus.joystick_1 = '0;
            if (bus.p2_coin) cnt++;
        end
        check("coin_single_len", 32'(cnt), CP + 1);

        // Retrigger five cycles after the first edge.
        @(negedge clk);
        bus.joystick_1 = 32'h100;
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1 || i == 6) bus.joystick_1 = '0;
            if (i == 5) bus.joystick_1 = 32'h100;
            if (bus.p2_coin) cnt++;
        end
        check("coin_retrigger_len", 32'(cnt), 16);

        // Key and joystick pause together toggle only once.
        @(negedge clk);
        bus.ps2_key    = {~bus.ps2_key[10], 1'b1, 1'b0, 8'h4D};
        bus.joystick_0 = 32'h200;
        cycles(10);
        check("pause_combined_on", 32'(bus.p1_pause), 1);
        @(negedge clk);
        bus.ps2_key    = {~bus.ps2_key[10], 1'b0, 1'b0, 8'h4D};
        bus.joystick_0 = '0;
        cycles(10);
        check("pause_held_after_release", 32'(bus.p1_pause), 1);
        send_key(1'b1, 1'b0, 8'h4D);
        cycles(10);
        check("pause_second_press", 32'(bus.p1_pause), 0);
        send_key(1'b0, 1'b0, 8'h4D);
        cycles(10);

        // Held coin key overlapping a joystick coin pulse stays one continuous run.
        send_key(1'b1, 1'b0, 8'h36);
        cnt = 0; first = -1; last = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 4) bus.joystick_1 = 32'h100;
            if (i == 5) bus.joystick_1 = '0;
            if (i == 6) bus.ps2_key = {~bus.ps2_key[10], 1'b0, 1'b0, 8'h36};
            if (bus.p2_coin) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
        end
        check("coin_key_joy_len", 32'(cnt), 11);
        check("coin_key_joy_contig", 32'(last - first + 1), 11);
        check("coin_key_joy_start", 32'(first), 3);

        // Async reset with pause latch set and coin counter mid-count.
        @(negedge clk);
        bus.joystick_0 = 32'h200;
        @(negedge clk);
        bus.joystick_0 = '0;
        cycles(5);
        check("pause_before_reset", 32'(bus.p1_pause), 1);
        @(negedge clk);
        bus.joystick_0 = 32'h100;
        @(negedge clk);
        bus.joystick_0 = '0;
        cycles(6);
        check("coin_live_before_reset", 32'(bus.p1_coin), 1);
        #1 rst = 1'b1;
        #1 check("async_reset_clears", 32'(dut_vec()), 0);
        cycles(2);
        rst = 1'b0;
        cycles(20);
        check("after_reset_idle", 32'(dut_vec()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
